// File: rtl/match_controller_if.sv
// Match controller signal bundle: frame/start/miss inputs toward the
// controller and ball-control / score outputs back to the datapath.
interface match_controller_if #(
  parameter int SCORE_W = 4
);
  logic               frame_tick;
  logic               start;
  logic               miss_left;
  logic               miss_right;
  logic               ball_hold;
  logic               ball_en;
  logic               serve_dir;
  logic [SCORE_W-1:0] score_left;
  logic [SCORE_W-1:0] score_right;
  logic               game_over;
  logic               winner;

  // Driver side: produces frame/start/miss, observes controller outputs.
  modport master (
    output frame_tick, start, miss_left, miss_right,
    input  ball_hold, ball_en, serve_dir, score_left, score_right,
           game_over, winner
  );

  // Controller side.
  modport slave (
    input  frame_tick, start, miss_left, miss_right,
    output ball_hold, ball_en, serve_dir, score_left, score_right,
           game_over, winner
  );
endinterface

// File: rtl/match_controller.sv
// Match-level sequencer for the pong ball datapath: serve countdown, miss
// detection, per-player scoring and game-over detection. Every output is a
// register loaded from the next-state decode, so outputs change on the same
// edge as the state they belong to.
module match_controller #(
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 30,
  parameter int SCORE_W      = 4
) (
  input  logic            clk,
  input  logic            rst,
  match_controller_if.slave bus
);

  localparam int CNT_MAX = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0]   POINT_LAST = CNT_W'(POINT_FRAMES - 1);
  localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SERVE = 3'd1;
  localparam logic [2:0] ST_PLAY  = 3'd2;
  localparam logic [2:0] ST_POINT = 3'd3;
  localparam logic [2:0] ST_OVER  = 3'd4;

  logic [2:0]         state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [SCORE_W-1:0] score_left_reg, score_left_next;
  logic [SCORE_W-1:0] score_right_reg, score_right_next;
  logic               serve_dir_reg, serve_dir_next;
  logic               hold_reg, hold_next;
  logic               en_reg, en_next;
  logic               over_reg, over_next;
  logic               winner_reg, winner_next;

  // Next-state, counter and score decode.
  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    score_left_next  = score_left_reg;
    score_right_next = score_right_reg;
    serve_dir_next   = serve_dir_reg;

    case (state_reg)
      ST_IDLE: begin
        if (bus.start) begin
          state_next       = ST_SERVE;
          score_left_next  = '0;
          score_right_next = '0;
          serve_dir_next   = 1'b0;
        end
      end
      ST_SERVE: begin
        if (bus.frame_tick) begin
          if (cnt_reg == SERVE_LAST) state_next = ST_PLAY;
          else                       cnt_next   = cnt_reg + 1'b1;
        end
      end
      ST_PLAY: begin
        // Leaving PLAY on the first miss cycle gives one point per miss event.
        if (bus.miss_left && !bus.miss_right) begin
          if (score_right_reg < WIN_VAL) score_right_next = score_right_reg + 1'b1;
          serve_dir_next = 1'b1;
          state_next     = ST_POINT;
        end else if (bus.miss_right && !bus.miss_left) begin
          if (score_left_reg < WIN_VAL) score_left_next = score_left_reg + 1'b1;
          serve_dir_next = 1'b0;
          state_next     = ST_POINT;
        end else if (bus.miss_left && bus.miss_right) begin
          state_next = ST_POINT;
        end
      end
      ST_POINT: begin
        if (bus.frame_tick) begin
          if (cnt_reg == POINT_LAST) begin
            if (score_left_reg == WIN_VAL || score_right_reg == WIN_VAL)
              state_next = ST_OVER;
            else
              state_next = ST_SERVE;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      ST_OVER: begin
        if (bus.start) begin
          state_next       = ST_SERVE;
          score_left_next  = '0;
          score_right_next = '0;
          serve_dir_next   = 1'b0;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Every state entry restarts the frame count.
    if (state_next != state_reg) cnt_next = '0;
  end

  // Output decode from the state being entered, so outputs register with it.
  always_comb begin
    hold_next   = (state_next == ST_IDLE) || (state_next == ST_SERVE) || (state_next == ST_OVER);
    en_next     = (state_next == ST_PLAY);
    over_next   = (state_next == ST_OVER);
    winner_next = (state_next == ST_OVER) && (score_right_next == WIN_VAL);
  end

  // State, counter, score and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      cnt_reg         <= '0;
      score_left_reg  <= '0;
      score_right_reg <= '0;
      serve_dir_reg   <= 1'b0;
      hold_reg        <= 1'b1;
      en_reg          <= 1'b0;
      over_reg        <= 1'b0;
      winner_reg      <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      score_left_reg  <= score_left_next;
      score_right_reg <= score_right_next;
      serve_dir_reg   <= serve_dir_next;
      hold_reg        <= hold_next;
      en_reg          <= en_next;
      over_reg        <= over_next;
      winner_reg      <= winner_next;
    end
  end

  assign bus.ball_hold   = hold_reg;
  assign bus.ball_en     = en_reg;
  assign bus.serve_dir   = serve_dir_reg;
  assign bus.score_left  = score_left_reg;
  assign bus.score_right = score_right_reg;
  assign bus.game_over   = over_reg;
  assign bus.winner      = winner_reg;

endmodule

// File: tb/tb_match_controller.sv
// Directed bench for match_controller with a short serve/point countdown
// and WIN_SCORE=2.
module tb_match_controller;

  localparam int WIN_SCORE    = 2;
  localparam int SERVE_FRAMES = 4;
  localparam int POINT_FRAMES = 3;
  localparam int SCORE_W      = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  match_controller_if #(.SCORE_W(SCORE_W)) bus ();

  match_controller #(
    .WIN_SCORE(WIN_SCORE),
    .SERVE_FRAMES(SERVE_FRAMES),
    .POINT_FRAMES(POINT_FRAMES),
    .SCORE_W(SCORE_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expectation.
  task automatic check_val(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end else begin
      $display("ok   %s: %0d", tag, act);
    end
  endtask

  // Advance one clock; returns 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle frame_tick pulse.
  task automatic tick();
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic miss(input logic l, input logic r);
    bus.miss_left  = l;
    bus.miss_right = r;
    step();
    bus.miss_left  = 1'b0;
    bus.miss_right = 1'b0;
  endtask

  task automatic check_outs(input string tag, input int hold, input int en,
                            input int sl, input int sr, input int dir,
                            input int over, input int win);
    check_val({tag, ".hold"},   int'(bus.ball_hold),   hold);
    check_val({tag, ".en"},     int'(bus.ball_en),     en);
    check_val({tag, ".sl"},     int'(bus.score_left),  sl);
    check_val({tag, ".sr"},     int'(bus.score_right), sr);
    check_val({tag, ".dir"},    int'(bus.serve_dir),   dir);
    check_val({tag, ".over"},   int'(bus.game_over),   over);
    check_val({tag, ".winner"}, int'(bus.winner),      win);
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst            = 1'b1;
    bus.frame_tick = 1'b0;
    bus.start      = 1'b0;
    bus.miss_left  = 1'b0;
    bus.miss_right = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    check_outs("reset", 1, 0, 0, 0, 0, 0, 0);

    // Idle 1000 cycles with frame ticks and stray misses; nothing may move.
    for (int i = 0; i < 1000; i++) begin
      bus.frame_tick = (i % 7 == 0);
      bus.miss_left  = (i % 13 == 0);
      step();
    end
    bus.frame_tick = 1'b0;
    bus.miss_left  = 1'b0;
    check_outs("idle1000", 1, 0, 0, 0, 0, 0, 0);

    // Serve countdown: three ticks keep the ball held, the fourth releases.
    pulse_start();
    check_outs("serve_entry", 1, 0, 0, 0, 0, 0, 0);
    ticks(3);
    check_outs("serve_3ticks", 1, 0, 0, 0, 0, 0, 0);
    tick();
    check_outs("serve_release", 0, 1, 0, 0, 0, 0, 0);

    // start ignored during PLAY.
    pulse_start();
    check_outs("play_start_ign", 0, 1, 0, 0, 0, 0, 0);

    // miss_left held three cycles scores a single point.
    bus.miss_left = 1'b1;
    step();
    check_outs("missl_first", 0, 0, 0, 1, 1, 0, 0);
    step();
    step();
    bus.miss_left = 1'b0;
    check_outs("missl_held", 0, 0, 0, 1, 1, 0, 0);
    ticks(2);
    check_outs("point_2ticks", 0, 0, 0, 1, 1, 0, 0);
    tick();
    check_outs("point_to_serve", 1, 0, 0, 1, 1, 0, 0);
    ticks(4);
    check_outs("play2", 0, 1, 0, 1, 1, 0, 0);

    // Simultaneous misses: no score change, direction kept, POINT entered.
    miss(1'b1, 1'b1);
    check_outs("both_miss", 0, 0, 0, 1, 1, 0, 0);
    ticks(3);
    check_outs("both_to_serve", 1, 0, 0, 1, 1, 0, 0);
    ticks(4);

    // Two right misses give left the match.
    miss(1'b0, 1'b1);
    check_outs("missr_1", 0, 0, 1, 1, 0, 0, 0);
    ticks(3);
    ticks(4);
    check_outs("play4", 0, 1, 1, 1, 0, 0, 0);
    miss(1'b0, 1'b1);
    check_outs("missr_2", 0, 0, 2, 1, 0, 0, 0);
    pulse_start();
    check_outs("point_start_ign", 0, 0, 2, 1, 0, 0, 0);
    ticks(2);
    check_outs("point_pre_over", 0, 0, 2, 1, 0, 0, 0);
    tick();
    check_outs("over_left", 1, 0, 2, 1, 0, 1, 0);
    ticks(5);
    check_outs("over_stays", 1, 0, 2, 1, 0, 1, 0);
    pulse_start();
    check_outs("over_restart", 1, 0, 0, 0, 0, 0, 0);

    // Right player wins the next match.
    ticks(4);
    miss(1'b1, 1'b0);
    ticks(3);
    ticks(4);
    miss(1'b1, 1'b0);
    check_outs("missl_2", 0, 0, 0, 2, 1, 0, 0);
    ticks(3);
    check_outs("over_right", 1, 0, 0, 2, 1, 1, 1);

    // Reset in the middle of POINT with score_left=1.
    pulse_start();
    ticks(4);
    miss(1'b0, 1'b1);
    check_outs("pre_rst_point", 0, 0, 1, 0, 0, 0, 0);
    tick();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_outs("rst_mid_point", 1, 0, 0, 0, 0, 0, 0);
    ticks(6);
    check_outs("after_rst_idle", 1, 0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
